// File: rtl/hyper_pipe_vr_pkg.sv
// Shared types and helpers for the hyper_pipe_vr valid/ready pipeline.
//   stage_state_e : occupancy state of one 2-entry skid slice
//   occ_width()   : width of the occupancy count for a given stage count
package hyper_pipe_vr_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // m and s invalid
    ST_ONE   = 2'd1,  // m valid
    ST_FULL  = 2'd2   // m and s valid
  } stage_state_e;

  // Occupancy ranges 0..2*n; a zero-stage pipe still gets a 1-bit port.
  function automatic int occ_width(input int n);
    return (n == 0) ? 1 : $clog2(2 * n + 1);
  endfunction

endpackage

// File: rtl/hyper_pipe_vr_stage.sv
// One 2-entry skid slice of the hyper-pipeline.
//   clk, rst   : clock, synchronous active-high reset
//   in_data    : upstream payload (WIDTH)
//   in_valid   : upstream beat valid
//   in_ready   : slice can accept; decoded from the state flops only
//   out_data   : downstream payload (WIDTH), always the main register
//   out_valid  : main register holds a beat
//   out_ready  : downstream accepts
// The skid register absorbs the beat that arrives in the cycle the
// downstream stall becomes visible, so in_ready never has to look at
// out_ready combinationally.
module hyper_pipe_vr_stage
  import hyper_pipe_vr_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter bit RESET_DATA = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  stage_state_e     state, state_nxt;
  logic [WIDTH-1:0] m_data_p0;
  logic [WIDTH-1:0] s_data_p0;
  logic             push, pop;
  logic             load_m, load_s, m_from_s;

  assign in_ready  = (state != ST_FULL);
  assign out_valid = (state != ST_EMPTY);
  assign out_data  = m_data_p0;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    load_m    = 1'b0;
    load_s    = 1'b0;
    m_from_s  = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (push) begin
          state_nxt = ST_ONE;
          load_m    = 1'b1;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          load_m = 1'b1;
        end else if (push) begin
          state_nxt = ST_FULL;
          load_s    = 1'b1;
        end else if (pop) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_nxt = ST_ONE;
          m_from_s  = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_nxt;
  end

  // ---- stage register boundary: main / skid payload ----
  always_ff @(posedge clk) begin
    if (RESET_DATA && rst) begin
      m_data_p0 <= '0;
      s_data_p0 <= '0;
    end else begin
      if (load_m)        m_data_p0 <= in_data;
      else if (m_from_s) m_data_p0 <= s_data_p0;
      if (load_s)        s_data_p0 <= in_data;
    end
  end

endmodule

// File: rtl/hyper_pipe_vr.sv
// Valid/ready hyper-pipeline: NUM_STAGES cascaded skid slices.
//   clk, rst   : clock, synchronous active-high reset
//   in_data    : upstream payload (WIDTH)
//   in_valid   : upstream beat valid
//   in_ready   : pipe can accept (registered unless NUM_STAGES = 0)
//   out_data   : downstream payload (WIDTH)
//   out_valid  : downstream beat valid
//   out_ready  : downstream accepts
//   occupancy  : beats held in the pipe, 0..2*NUM_STAGES (OCC_W bits)
// NUM_STAGES = 0 degenerates to wires and a constant zero occupancy.
module hyper_pipe_vr
  import hyper_pipe_vr_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int NUM_STAGES = 2,
  parameter bit RESET_DATA = 1'b0,
  parameter int OCC_W      = occ_width(NUM_STAGES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OCC_W-1:0] occupancy
);

  if (NUM_STAGES == 0) begin : g_pass
    logic unused_clkrst;
    assign unused_clkrst = clk ^ rst;
    assign out_data      = in_data;
    assign out_valid     = in_valid;
    assign in_ready      = out_ready;
    assign occupancy     = '0;
  end else begin : g_pipe
    logic [WIDTH-1:0] data_p [NUM_STAGES+1];
    logic             vld_p  [NUM_STAGES+1];
    logic             rdy_p  [NUM_STAGES+1];
    logic             in_fire, out_fire;
    logic [OCC_W-1:0] occ_q;

    assign data_p[0]          = in_data;
    assign vld_p[0]           = in_valid;
    assign in_ready           = rdy_p[0];
    assign out_data           = data_p[NUM_STAGES];
    assign out_valid          = vld_p[NUM_STAGES];
    assign rdy_p[NUM_STAGES]  = out_ready;

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
      // ---- slice i: data_p[i] -> data_p[i+1] ----
      hyper_pipe_vr_stage #(
        .WIDTH      (WIDTH),
        .RESET_DATA (RESET_DATA)
      ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .in_data   (data_p[i]),
        .in_valid  (vld_p[i]),
        .in_ready  (rdy_p[i]),
        .out_data  (data_p[i+1]),
        .out_valid (vld_p[i+1]),
        .out_ready (rdy_p[i+1])
      );
    end

    assign in_fire  = in_valid && rdy_p[0];
    assign out_fire = vld_p[NUM_STAGES] && out_ready;

    // ---- occupancy register: net beats in minus beats out ----
    always_ff @(posedge clk) begin
      if (rst) begin
        occ_q <= '0;
      end else if (in_fire && !out_fire) begin
        occ_q <= occ_q + OCC_W'(1);
      end else if (out_fire && !in_fire) begin
        occ_q <= occ_q - OCC_W'(1);
      end
    end

    assign occupancy = occ_q;
  end

endmodule

// File: tb/tb_hyper_pipe_vr.sv
// Bench for hyper_pipe_vr: five registered pipes (NUM_STAGES 3,2,1,4 and a
// RESET_DATA=1 copy with 2 stages) plus a zero-stage pass-through, all fed
// from one stimulus stream. Each registered pipe is modelled as an ideal
// FIFO of capacity 2*NUM_STAGES holding exactly the beats it accepted.
module tb_hyper_pipe_vr;

  localparam int W  = 16;
  localparam int NI = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [W-1:0] in_data;

  logic         in_ready_a  [NI];
  logic         out_valid_a [NI];
  logic [W-1:0] out_data_a  [NI];
  logic [3:0]   occ_a       [NI];

  logic         in_ready_pt, out_valid_pt;
  logic [W-1:0] out_data_pt;
  logic [0:0]   occ_pt;

  function automatic int ns_of(input int i);
    case (i)
      0:       return 3;
      1:       return 2;
      2:       return 1;
      3:       return 4;
      default: return 2;
    endcase
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int NSG = (g == 0) ? 3 : (g == 1) ? 2 : (g == 2) ? 1 : (g == 3) ? 4 : 2;
    localparam int OW  = $clog2(2 * NSG + 1);
    logic [OW-1:0] occ_l;
    logic          ir, ov;
    logic [W-1:0]  od;
    hyper_pipe_vr #(
      .WIDTH      (W),
      .NUM_STAGES (NSG),
      .RESET_DATA ((g == 4) ? 1'b1 : 1'b0)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (ir),
      .out_data  (od),
      .out_valid (ov),
      .out_ready (out_ready),
      .occupancy (occ_l)
    );
    assign in_ready_a[g]  = ir;
    assign out_valid_a[g] = ov;
    assign out_data_a[g]  = od;
    assign occ_a[g]       = 4'(occ_l);
  end

  hyper_pipe_vr #(
    .WIDTH      (W),
    .NUM_STAGES (0)
  ) u_pt (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready_pt),
    .out_data  (out_data_pt),
    .out_valid (out_valid_pt),
    .out_ready (out_ready),
    .occupancy (occ_pt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s[%0d] actual=%0d required=%0d", nm, idx, act, exp);
    end
  endtask

  // Reference model state
  logic [W-1:0] exp_q [NI][$];
  int           cnt   [NI];
  int           acc_n [NI];
  int           del_n [NI];
  logic         prev_stall [NI];
  logic [W-1:0] prev_data  [NI];
  logic         prev_rst = 1'b1;
  int           cyc = 0;

  // Streaming statistics for the 3-stage pipe
  logic armed = 1'b0;
  int   first_acc = -1, first_out = -1, last_out = -1, sgap = 0, sdel = 0;

  initial begin
    for (int i = 0; i < NI; i++) begin
      cnt[i] = 0; acc_n[i] = 0; del_n[i] = 0;
      prev_stall[i] = 1'b0; prev_data[i] = '0;
    end
  end

  // Monitor: samples mid-cycle, compares against the FIFO model and then
  // applies the transfers that the coming edge will perform.
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < NI; i++) begin
      chk("occupancy", i, int'(occ_a[i]), cnt[i]);
      if (prev_stall[i] && !prev_rst) begin
        chk("hold_valid", i, int'(out_valid_a[i]), 1);
        chk("hold_data", i, int'(out_data_a[i]), int'(prev_data[i]));
      end
      if (rst) begin
        exp_q[i].delete();
        cnt[i] = 0;
      end else begin
        if (out_valid_a[i] && out_ready) begin
          if (exp_q[i].size() == 0) begin
            total++; bad++;
            $display("FAIL out_unexpected[%0d] actual=%0h required=no_beat", i, out_data_a[i]);
          end else begin
            chk("out_data", i, int'(out_data_a[i]), int'(exp_q[i].pop_front()));
          end
          del_n[i]++;
          cnt[i]--;
          if (i == 0 && armed) begin
            if (first_out < 0) first_out = cyc;
            else if (cyc != last_out + 1) sgap++;
            last_out = cyc;
            sdel++;
          end
        end
        if (in_valid && in_ready_a[i]) begin
          chk("capacity", i, int'(cnt[i] < 2 * ns_of(i)), 1);
          exp_q[i].push_back(in_data);
          cnt[i]++;
          acc_n[i]++;
          if (i == 0 && armed && first_acc < 0) first_acc = cyc;
        end
      end
      prev_stall[i] = out_valid_a[i] && !out_ready;
      prev_data[i]  = out_data_a[i];
    end
    chk("pt_valid", 0, int'(out_valid_pt), int'(in_valid));
    chk("pt_data", 0, int'(out_data_pt), int'(in_data));
    chk("pt_ready", 0, int'(in_ready_pt), int'(out_ready));
    chk("pt_occ", 0, int'(occ_pt), 0);
    prev_rst = rst;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int   base [NI];
  int   rec  [NI];
  logic ir_snap [NI];
  logic or_now;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (3) step();
    for (int i = 0; i < NI; i++) begin
      chk("rst_in_ready", i, int'(in_ready_a[i]), 1);
      chk("rst_out_valid", i, int'(out_valid_a[i]), 0);
      chk("rst_occ", i, int'(occ_a[i]), 0);
    end
    rst = 1'b0;

    // Streaming 0..99 with the sink always ready
    out_ready = 1'b1;
    armed = 1'b1;
    for (int k = 0; k < 100; k++) begin
      in_valid = 1'b1;
      in_data  = W'(k);
      if (k == 50)
        for (int i = 0; i < NI; i++) chk("stream_occ", i, int'(occ_a[i]), ns_of(i));
      step();
    end
    in_valid = 1'b0;
    repeat (8) step();
    armed = 1'b0;
    chk("stream_latency", 0, first_out - first_acc, 3);
    chk("stream_beats", 0, sdel, 100);
    chk("stream_gaps", 0, sgap, 0);

    // Full stall: each pipe must absorb exactly 2*NUM_STAGES beats
    for (int i = 0; i < NI; i++) base[i] = acc_n[i];
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 12; k++) begin
      in_data = W'($urandom);
      step();
    end
    for (int i = 0; i < NI; i++) begin
      chk("stall_accepted", i, acc_n[i] - base[i], 2 * ns_of(i));
      chk("stall_in_ready", i, int'(in_ready_a[i]), 0);
      chk("stall_occ", i, int'(occ_a[i]), 2 * ns_of(i));
      rec[i] = -1;
    end

    // Resume: in_ready must recover within NUM_STAGES edges
    out_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      in_data = W'($urandom);
      step();
      for (int i = 0; i < NI; i++)
        if (rec[i] < 0 && in_ready_a[i]) rec[i] = k;
    end
    for (int i = 0; i < NI; i++)
      chk("resume_within_ns", i, int'(rec[i] >= 1 && rec[i] <= ns_of(i)), 1);
    in_valid = 1'b0;
    repeat (20) step();

    // Reset mid-stream with three beats in the 3-stage pipe
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = W'(16'hA000 + k);
      step();
    end
    chk("pre_rst_occ", 0, int'(occ_a[0]), 3);
    rst = 1'b1;
    out_ready = 1'b1;
    in_data = 16'hBEEF;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < NI; i++) begin
      chk("midrst_out_valid", i, int'(out_valid_a[i]), 0);
      chk("midrst_in_ready", i, int'(in_ready_a[i]), 1);
      chk("midrst_occ", i, int'(occ_a[i]), 0);
    end
    chk("midrst_data_cleared", 4, int'(out_data_a[4]), 0);
    repeat (10) step();

    // Alternating sink with a mid-cycle out_ready flip
    base[2] = del_n[2];
    in_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      out_ready = k[0];
      in_data   = W'($urandom);
      #2;
      for (int i = 0; i < NI; i++) ir_snap[i] = in_ready_a[i];
      or_now    = ~out_ready;
      out_ready = or_now;
      #1;
      for (int i = 0; i < NI; i++)
        chk("ready_comb_indep", i, int'(in_ready_a[i]), int'(ir_snap[i]));
      chk("pt_ready_follows", 0, int'(in_ready_pt), int'(or_now));
      out_ready = ~out_ready;
      step();
    end
    chk("alt_progress", 2, int'((del_n[2] - base[2]) >= 10), 1);

    // Random traffic
    for (int k = 0; k < 20000; k++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = W'($urandom);
      step();
    end

    // Drain and confirm nothing is left undelivered
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (30) step();
    for (int i = 0; i < NI; i++) begin
      chk("drain_left", i, exp_q[i].size(), 0);
      chk("drain_occ", i, int'(occ_a[i]), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
